framer_source_scan_ctrl: RTL and testbench

//   Sequences the single bit-framer across several candidate demod bit streams.

---
 rtl/framer_source_scan_ctrl_pkg.sv | 11 +
 rtl/framer_source_scan_ctrl_next_source.sv | 25 ++
 rtl/framer_source_scan_ctrl.sv | 93 +++++++++
 tb/tb_framer_source_scan_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/framer_source_scan_ctrl_pkg.sv
// framer_source_scan_ctrl_pkg: shared scan state encodings and lossCount width
package framer_source_scan_ctrl_pkg;
  typedef enum logic [2:0] {
    SCAN_IDLE   = 3'd0,
    SCAN_SETTLE = 3'd1,
    SCAN_SEARCH = 3'd2,
    SCAN_LOCKED = 3'd3,
    SCAN_NEXT   = 3'd4
  } scan_state_e;
  localparam int LOSS_W = 8;
endpackage

// File: rtl/framer_source_scan_ctrl_next_source.sv
// scan_next_source: round-robin finder of the next set mask bit strictly above cur, wrapping
module scan_next_source #(
  parameter int NUM_SOURCES = 4,
  parameter int SEL_W       = 4
) (
  input  logic [NUM_SOURCES-1:0] mask,
  input  logic [SEL_W-1:0]       cur,
  output logic [SEL_W-1:0]       nxt,
  output logic                   valid
);
  always_comb begin
    int best;
    int d;
    nxt   = '0;
    best  = NUM_SOURCES;
    valid = |mask;
    for (int j = 0; j < NUM_SOURCES; j++) begin
      d = (j + 2 * NUM_SOURCES - int'(cur) - 1) % NUM_SOURCES;
      if (mask[j] && d < best) begin
        best = d;
        nxt  = SEL_W'(j);
      end
    end
  end
endmodule

// File: rtl/framer_source_scan_ctrl.sv
// framer_source_scan_ctrl: round-robin framer source scanner with settle/dwell timing and lock tracking
module framer_source_scan_ctrl
  import framer_source_scan_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int SEL_W       = 4,
  parameter int CNT_W       = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clkEn,
  input  logic                   enable,
  input  logic [NUM_SOURCES-1:0] sourceMask,
  input  logic [CNT_W-1:0]       settleBits,
  input  logic [CNT_W-1:0]       dwellBits,
  input  logic                   framesync,
  output logic [SEL_W-1:0]       sourceSel,
  output logic                   framerReset,
  output logic                   locked,
  output logic                   scanning,
  output logic [LOSS_W-1:0]      lossCount
);
  scan_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] sel_n, nxt, cur;
  logic [LOSS_W-1:0] loss_n;
  logic [NUM_SOURCES-1:0] mask_sh;
  logic nxt_valid, cur_en, cnt_zero;
  assign mask_sh  = sourceMask >> sourceSel;
  assign cur_en   = mask_sh[0];
  assign cnt_zero = cnt == '0;
  // From IDLE, searching above the top index wraps to the lowest set bit
  assign cur = (state == SCAN_IDLE) ? SEL_W'(NUM_SOURCES - 1) : sourceSel;
  scan_next_source #(.NUM_SOURCES(NUM_SOURCES), .SEL_W(SEL_W)) u_next (
    .mask  (sourceMask),
    .cur   (cur),
    .nxt   (nxt),
    .valid (nxt_valid)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sourceSel;
    loss_n  = lossCount;
    if (!enable || !nxt_valid)
      state_n = SCAN_IDLE;
    else if (state inside {SCAN_SETTLE, SCAN_SEARCH, SCAN_LOCKED} && !cur_en)
      state_n = SCAN_NEXT;
    else
      case (state)
        SCAN_IDLE, SCAN_NEXT: begin
          state_n = SCAN_SETTLE;
          cnt_n   = settleBits;
          sel_n   = nxt;
        end
        SCAN_SETTLE: if (clkEn) begin
          state_n = cnt_zero ? SCAN_SEARCH : SCAN_SETTLE;
          cnt_n   = cnt_zero ? dwellBits : cnt - CNT_W'(1);
        end
        SCAN_SEARCH:
          if (framesync) state_n = SCAN_LOCKED;
          else if (clkEn) begin
            state_n = cnt_zero ? SCAN_NEXT : SCAN_SEARCH;
            cnt_n   = cnt_zero ? cnt : cnt - CNT_W'(1);
          end
        SCAN_LOCKED: if (!framesync) begin
          state_n = SCAN_SEARCH;
          cnt_n   = dwellBits;
          loss_n  = (lossCount == '1) ? lossCount : lossCount + LOSS_W'(1);
        end
        default: state_n = SCAN_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN_IDLE;
      cnt         <= '0;
      sourceSel   <= '0;
      framerReset <= 1'b1;
      locked      <= 1'b0;
      scanning    <= 1'b0;
      lossCount   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sourceSel   <= sel_n;
      lossCount   <= loss_n;
      framerReset <= !(state_n inside {SCAN_SEARCH, SCAN_LOCKED});
      locked      <= state_n == SCAN_LOCKED;
      scanning    <= state_n inside {SCAN_SETTLE, SCAN_SEARCH, SCAN_NEXT};
    end
  end
endmodule

// File: tb/tb_framer_source_scan_ctrl.sv
// tb_framer_source_scan_ctrl: randomized scoreboard bench against a tick-counting reference model
module tb_framer_source_scan_ctrl;
  localparam int N  = 4;
  localparam int SW = 4;
  localparam int CW = 24;
  localparam int P_IDLE = 0, P_SETTLE = 1, P_SEARCH = 2, P_LOCKED = 3, P_NEXT = 4;
  typedef struct packed {
    logic [SW-1:0] sel;
    logic          frst;
    logic          lck;
    logic          scn;
    logic [7:0]    loss;
  } obs_t;
  logic clk = 0, reset = 1, clkEn = 0, enable = 0, framesync = 0;
  logic [N-1:0] sourceMask = '0;
  logic [CW-1:0] settleBits = '0, dwellBits = '0;
  logic [SW-1:0] sourceSel;
  logic framerReset, locked, scanning;
  logic [7:0] lossCount;
  obs_t exp_q[$];
  obs_t e;
  int checks = 0, errors = 0;
  int m_phase = P_IDLE, m_sel = 0, m_left = 0, m_loss = 0;
  always #5 clk = ~clk;
  framer_source_scan_ctrl #(.NUM_SOURCES(N), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clkEn       (clkEn),
    .enable      (enable),
    .sourceMask  (sourceMask),
    .settleBits  (settleBits),
    .dwellBits   (dwellBits),
    .framesync   (framesync),
    .sourceSel   (sourceSel),
    .framerReset (framerReset),
    .locked      (locked),
    .scanning    (scanning),
    .lossCount   (lossCount)
  );
  function automatic bit has(int j);
    return ((int'(sourceMask) >> j) & 1) != 0;
  endfunction
  function automatic int first_from(int start);
    for (int k = 0; k < N; k++) if (has((start + k) % N)) return (start + k) % N;
    return 0;
  endfunction
  task automatic enter_settle();
    m_phase = P_SETTLE;
    m_left  = int'(settleBits) + 1;
  endtask
  task automatic model_step();
    if (reset) begin
      m_phase = P_IDLE; m_sel = 0; m_left = 0; m_loss = 0;
    end else if (!enable || sourceMask == 0) m_phase = P_IDLE;
    else if ((m_phase == P_SETTLE || m_phase == P_SEARCH || m_phase == P_LOCKED) && !has(m_sel))
      m_phase = P_NEXT;
    else if (m_phase == P_IDLE) begin
      m_sel = first_from(0); enter_settle();
    end else if (m_phase == P_NEXT) begin
      m_sel = first_from(m_sel + 1); enter_settle();
    end else if (m_phase == P_SETTLE) begin
      if (clkEn) m_left--;
      if (m_left == 0) begin m_phase = P_SEARCH; m_left = int'(dwellBits) + 1; end
    end else if (m_phase == P_SEARCH) begin
      if (framesync) m_phase = P_LOCKED;
      else begin
        if (clkEn) m_left--;
        if (m_left == 0) m_phase = P_NEXT;
      end
    end else if (!framesync) begin
      m_phase = P_SEARCH; m_left = int'(dwellBits) + 1;
      if (m_loss < 255) m_loss++;
    end
    exp_q.push_back('{sel: SW'(m_sel),
                      frst: !(m_phase == P_SEARCH || m_phase == P_LOCKED),
                      lck: m_phase == P_LOCKED,
                      scn: m_phase == P_SETTLE || m_phase == P_SEARCH || m_phase == P_NEXT,
                      loss: 8'(m_loss)});
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (exp_q.size() > 0) begin
    e = exp_q.pop_front();
    chk("sourceSel", int'(sourceSel), int'(e.sel));
    chk("framerReset", int'(framerReset), int'(e.frst));
    chk("locked", int'(locked), int'(e.lck));
    chk("scanning", int'(scanning), int'(e.scn));
    chk("lossCount", int'(lossCount), int'(e.loss));
  end
  initial begin
    reset = 1; cyc(); cyc();
    reset = 0; enable = 1; sourceMask = 4'b1111; settleBits = 3; dwellBits = 20;
    for (int i = 0; i < 200; i++) begin clkEn = (i % 2 == 0); cyc(); end
    sourceMask = 4'b0110; clkEn = 1;
    for (int i = 0; i < 60; i++) begin
      framesync = (m_phase == P_SEARCH && m_sel == 1) || m_phase == P_LOCKED;
      cyc();
    end
    framesync = 0;
    for (int i = 0; i < 80; i++) cyc();
    for (int i = 0; i < 150; i++) begin
      framesync = m_phase == P_SEARCH && m_left == 1;
      cyc();
    end
    framesync = 0; sourceMask = 4'b0010;
    for (int i = 0; i < 40; i++) begin framesync = m_phase != P_IDLE && m_sel == 1; cyc(); end
    sourceMask = 4'b1001;
    for (int i = 0; i < 10; i++) cyc();
    framesync = 0;
    for (int i = 0; i < 3; i++) cyc();
    enable = 0; cyc(); cyc();
    enable = 1;
    for (int i = 0; i < 30; i++) cyc();
    reset = 1; cyc(); reset = 0;
    for (int i = 0; i < 3000; i++) begin
      clkEn = $urandom_range(3) != 0;
      if ($urandom_range(9) == 0) framesync = ~framesync;
      if ($urandom_range(39) == 0) begin
        sourceMask = N'($urandom_range(15));
        settleBits = CW'($urandom_range(3));
        dwellBits  = CW'($urandom_range(8));
      end
      enable = $urandom_range(59) != 0;
      reset  = $urandom_range(299) == 0;
      cyc();
    end
    reset = 0; enable = 1; sourceMask = 4'b0001; settleBits = 0; dwellBits = 50; clkEn = 1;
    for (int i = 0; i < 1400; i++) begin framesync = (i / 2) % 2 == 0; cyc(); end
    reset = 1; cyc(); cyc();
    @(negedge clk); @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
